// File: rtl/galois8_pkg.sv
// Shared GF(2^8) types, constants and the reference field multiply used by the
// Galois8Mul pipeline and the dot-product accumulator.
package galois8_pkg;

   localparam int GF8_W              = 8;
   localparam int GALOIS8MUL_LATENCY = 9;

   // Reduction polynomial x^8 + x^7 + x^6 + x + 1, x^8 term implied.
   localparam logic [GF8_W-1:0] GF8_POLY = 8'hC3;

   typedef logic [GF8_W-1:0] gf8_t;

   typedef struct packed {
      logic valid;
      logic last;
   } mul_tag_t;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_t;

   function automatic gf8_t gf8_mul(input gf8_t a, input gf8_t b);
      gf8_t prod;
      gf8_t shifted;
      prod    = '0;
      shifted = a;
      for (int i = 0; i < GF8_W; i++) begin
         if (b[i]) prod = prod ^ shifted;
         shifted = {shifted[GF8_W-2:0], 1'b0} ^ (shifted[GF8_W-1] ? GF8_POLY : '0);
      end
      return prod;
   endfunction

endpackage

// File: rtl/galois8_dot_acc_if.sv
// Operand, multiplier-side and frame-result signals of galois8_dot_acc.
interface galois8_dot_acc_if
   import galois8_pkg::*;
#(
   parameter int CNT_W = 8
) ();

   // No backpressure anywhere: a term is taken on every edge where in_valid is
   // high, and out_valid is a one-cycle pulse with no ready to wait for.
   logic             in_valid;
   logic             in_last;
   gf8_t             in_left;
   gf8_t             in_right;
   gf8_t             mul_left;
   gf8_t             mul_right;
   gf8_t             mul_result;
   logic             out_valid;
   gf8_t             out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_sat;
   logic             busy;
   acc_state_t       dbg_state;

   modport master (
      output in_valid, in_last, in_left, in_right, mul_result,
      input  mul_left, mul_right, out_valid, out_data, out_count, out_sat, busy, dbg_state
   );

   modport slave (
      input  in_valid, in_last, in_left, in_right, mul_result,
      output mul_left, mul_right, out_valid, out_data, out_count, out_sat, busy, dbg_state
   );

endinterface

// File: rtl/Galois8Mul.sv
// Fixed-latency GF(2^8) multiplier; it has no reset, so its pipeline contents are
// meaningful only where a matching tag says so.
module Galois8Mul
   import galois8_pkg::*;
#(
   parameter int LATENCY = GALOIS8MUL_LATENCY
) (
   input  logic clk,
   input  gf8_t left,
   input  gf8_t right,
   output gf8_t result
);

   gf8_t pipe_q [LATENCY];
   gf8_t pipe_d [LATENCY];

   always_comb begin
      pipe_d[0] = gf8_mul(left, right);
      for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
   end

   always_ff @(posedge clk) begin
      pipe_q <= pipe_d;
   end

   assign result = pipe_q[LATENCY-1];

endmodule

// File: rtl/galois8_tag_delay.sv
// Shift register that carries per-term tags alongside the multiplier pipeline so
// stage DEPTH lines up with the multiplier result.
module galois8_tag_delay
   import galois8_pkg::*;
#(
   parameter int  DEPTH = GALOIS8MUL_LATENCY,
   parameter type T     = mul_tag_t
) (
   input  logic clk,
   input  logic rst_n,
   input  T     din,
   output T     dout,
   output logic any_valid
);

   T pipe_q [DEPTH];
   T pipe_d [DEPTH];

   always_comb begin
      pipe_d[0] = din;
      for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) any_valid = any_valid | pipe_q[i].valid;
   end

   assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/galois8_dot_acc.sv
// GF(2^8) dot-product stage: feeds an external Galois8Mul, delays the tags to its
// latency and XOR-accumulates returned products into one result per frame.
module galois8_dot_acc
   import galois8_pkg::*;
#(
   parameter int MUL_LATENCY = GALOIS8MUL_LATENCY,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   galois8_dot_acc_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   mul_tag_t         in_tag;
   mul_tag_t         mul_tag;
   logic             tags_busy;

   acc_state_t       state_q, state_d;
   gf8_t             acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;

   gf8_t             frame_acc;
   logic [CNT_W-1:0] frame_cnt;
   logic             frame_sat;

   logic             out_valid_q, out_valid_d;
   gf8_t             out_data_q, out_data_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             out_sat_q, out_sat_d;

   // Zero operands on bubbles keep the untagged multiplier slots inert.
   assign bus.mul_left  = bus.in_valid ? bus.in_left  : '0;
   assign bus.mul_right = bus.in_valid ? bus.in_right : '0;

   always_comb begin
      in_tag.valid = bus.in_valid;
      in_tag.last  = bus.in_valid & bus.in_last;
   end

   galois8_tag_delay #(
      .DEPTH (MUL_LATENCY),
      .T     (mul_tag_t)
   ) u_tag_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (in_tag),
      .dout      (mul_tag),
      .any_valid (tags_busy)
   );

   // Frame totals including the product arriving this cycle.
   always_comb begin
      frame_acc = bus.mul_result;
      frame_cnt = CNT_W'(1);
      frame_sat = 1'b0;
      case (state_q)
         IDLE: begin
            frame_acc = bus.mul_result;
            frame_cnt = CNT_W'(1);
            frame_sat = 1'b0;
         end
         ACCUM: begin
            frame_acc = acc_q ^ bus.mul_result;
            if (cnt_q == CNT_MAX) begin
               frame_cnt = cnt_q;
               frame_sat = 1'b1;
            end else begin
               frame_cnt = cnt_q + CNT_W'(1);
               frame_sat = sat_q;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_sat_d   = out_sat_q;
      case (state_q)
         IDLE, ACCUM: begin
            if (mul_tag.valid) begin
               if (mul_tag.last) begin
                  out_valid_d = 1'b1;
                  out_data_d  = frame_acc;
                  out_count_d = frame_cnt;
                  out_sat_d   = frame_sat;
                  acc_d       = '0;
                  cnt_d       = '0;
                  sat_d       = 1'b0;
                  state_d     = IDLE;
               end else begin
                  acc_d   = frame_acc;
                  cnt_d   = frame_cnt;
                  sat_d   = frame_sat;
                  state_d = ACCUM;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_count = out_count_q;
   assign bus.out_sat   = out_sat_q;
   assign bus.busy      = tags_busy | (state_q == ACCUM);
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_galois8_dot_acc.sv
// Randomised and directed bench for galois8_dot_acc driven through Galois8Mul,
// checked every cycle against a frame-level model of the dot product.
module tb_galois8_dot_acc;
   import galois8_pkg::*;

   localparam int LAT         = 9;
   localparam int CNT_W       = 8;
   localparam int CNT_MAX     = 255;
   localparam int PULSE_DELAY = LAT + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   galois8_dot_acc_if #(.CNT_W(CNT_W)) bus ();

   galois8_dot_acc #(
      .MUL_LATENCY (LAT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   Galois8Mul #(.LATENCY(LAT)) u_mul (
      .clk    (clk),
      .left   (bus.mul_left),
      .right  (bus.mul_right),
      .result (bus.mul_result)
   );

   int unsigned edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Carry-less product reduced by long division by x^8+x^7+x^6+x+1.
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) if (b[i]) c = c ^ (16'(a) << i);
      for (int k = 14; k >= 8; k--) if (c[k]) c = c ^ (16'h01C3 << (k - 8));
      return c[7:0];
   endfunction

   logic [16:0]  exp_q[$];      // {sat, count, data} per expected pulse
   int unsigned  due_q[$];      // edge count at which that pulse is visible
   int unsigned  hist_a[$];     // edge at which each accepted term was sampled
   bit           hist_last[$];
   logic [7:0]   m_acc = '0;
   int           m_cnt = 0;
   logic [16:0]  hold  = '0;
   logic [16:0]  pulse_q[$];
   int unsigned  pulse_e[$];
   int unsigned  last_drive_edge;

   function automatic void model_accept(input bit v, input bit l, input logic [7:0] a, input logic [7:0] b);
      if (!v) return;
      m_acc = m_acc ^ ref_mul(a, b);
      m_cnt++;
      hist_a.push_back(edge_cnt + 1);
      hist_last.push_back(l);
      if (l) begin
         exp_q.push_back({m_cnt > CNT_MAX, 8'((m_cnt > CNT_MAX) ? CNT_MAX : m_cnt), m_acc});
         due_q.push_back(edge_cnt + PULSE_DELAY);
         m_acc = '0;
         m_cnt = 0;
      end
   endfunction

   function automatic void model_clear();
      exp_q.delete();
      due_q.delete();
      hist_a.delete();
      hist_last.delete();
      m_acc = '0;
      m_cnt = 0;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      bit exp_busy;
      bit due;
      if (!rst_n) begin
         check("rst_out_valid", bus.out_valid, 0);
         check("rst_out_data", bus.out_data, 0);
         check("rst_out_count", bus.out_count, 0);
         check("rst_busy", bus.busy, 0);
         hold = '0;
      end else begin
         while (hist_a.size() >= 2 && hist_a[1] + LAT <= edge_cnt) begin
            void'(hist_a.pop_front());
            void'(hist_last.pop_front());
         end
         exp_busy = 1'b0;
         foreach (hist_a[i])
            if (hist_a[i] <= edge_cnt && edge_cnt <= hist_a[i] + LAT - 1) exp_busy = 1'b1;
         if (hist_a.size() > 0 && hist_a[0] + LAT <= edge_cnt && !hist_last[0]) exp_busy = 1'b1;

         if (due_q.size() > 0 && due_q[0] < edge_cnt) begin
            check("pulse_missed", edge_cnt, due_q[0]);
            void'(due_q.pop_front());
            hold = exp_q.pop_front();
         end
         due = (due_q.size() > 0 && due_q[0] == edge_cnt);
         check("out_valid", bus.out_valid, due);
         if (due) begin
            void'(due_q.pop_front());
            hold = exp_q.pop_front();
         end
         if (bus.out_valid) begin
            pulse_q.push_back({bus.out_sat, bus.out_count, bus.out_data});
            pulse_e.push_back(edge_cnt);
         end
         check("out_data", bus.out_data, hold[7:0]);
         check("out_count", bus.out_count, hold[15:8]);
         check("out_sat", bus.out_sat, hold[16]);
         check("busy", bus.busy, exp_busy);
         check("mul_left", bus.mul_left, bus.in_valid ? bus.in_left : 8'h00);
         check("mul_right", bus.mul_right, bus.in_valid ? bus.in_right : 8'h00);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input bit v, input bit l, input logic [7:0] a, input logic [7:0] b);
      @(posedge clk);
      #1;
      bus.in_valid = v;
      bus.in_last  = l;
      bus.in_left  = a;
      bus.in_right = b;
      last_drive_edge = edge_cnt;
      model_accept(v, l, a, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && due_q.size() > 0; i++) idle(1);
      idle(2);
      @(negedge clk);
      check("drain_empty", due_q.size(), 0);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      model_clear();
      #1;
      check("async_rst_busy", bus.busy, 0);
      check("async_rst_valid", bus.out_valid, 0);
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic expect_pulse(input string name, input int idx, input logic [7:0] d,
                               input logic [7:0] c, input logic s);
      if (pulse_q.size() <= idx) check({name, "_present"}, pulse_q.size(), idx + 1);
      else check(name, pulse_q[idx], {s, c, d});
   endtask

   function automatic void clear_pulses();
      pulse_q.delete();
      pulse_e.delete();
   endfunction

   // ---------------- stimulus ----------------
   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int unsigned t0;
      int len;
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_left  = '0;
      bus.in_right = '0;
      #2 rst_n = 1'b0;
      #1;
      check("reset_out_data", bus.out_data, 8'h00);
      check("reset_out_sat", bus.out_sat, 0);
      check("reset_busy", bus.busy, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // pin the reference multiply to known products
      check("ref_72x69", ref_mul(8'h72, 8'h69), 8'h8c);
      check("ref_01x35", ref_mul(8'h01, 8'h35), 8'h35);
      check("ref_02x80", ref_mul(8'h02, 8'h80), 8'hc3);

      // single term
      clear_pulses();
      drive(1, 1, 8'h72, 8'h69);
      t0 = last_drive_edge;
      drain();
      expect_pulse("single", 0, 8'h8c, 8'd1, 1'b0);
      check("single_latency", pulse_e.size() > 0 ? pulse_e[0] - t0 : 0, 10);

      // two terms, then the same with three bubbles between
      clear_pulses();
      drive(1, 0, 8'h01, 8'h35);
      drive(1, 1, 8'h72, 8'h69);
      drain();
      expect_pulse("two_terms", 0, 8'hb9, 8'd2, 1'b0);
      clear_pulses();
      drive(1, 0, 8'h01, 8'h35);
      idle(3);
      drive(1, 1, 8'h72, 8'h69);
      t0 = last_drive_edge;
      drain();
      expect_pulse("two_bubbles", 0, 8'hb9, 8'd2, 1'b0);
      check("bubbles_latency", pulse_e.size() > 0 ? pulse_e[0] - t0 : 0, 10);

      // back-to-back single-term frames
      clear_pulses();
      drive(1, 1, 8'h72, 8'h69);
      drive(1, 1, 8'h01, 8'h5a);
      drain();
      expect_pulse("b2b_first", 0, 8'h8c, 8'd1, 1'b0);
      expect_pulse("b2b_second", 1, 8'h5a, 8'd1, 1'b0);
      check("b2b_adjacent", pulse_e.size() > 1 ? pulse_e[1] - pulse_e[0] : 0, 1);

      // cancellation
      clear_pulses();
      drive(1, 0, 8'h72, 8'h69);
      drive(1, 1, 8'h72, 8'h69);
      drain();
      expect_pulse("cancel", 0, 8'h00, 8'd2, 1'b0);

      // largest unsaturated frame, then saturation, then a fresh frame
      clear_pulses();
      for (int i = 0; i < 255; i++) drive(1, i == 254, 8'h01, 8'h01);
      drain();
      expect_pulse("full_255", 0, 8'h01, 8'd255, 1'b0);
      clear_pulses();
      for (int i = 0; i < 300; i++) drive(1, i == 299, 8'h01, 8'h01);
      drain();
      expect_pulse("sat_300", 0, 8'h00, 8'd255, 1'b1);
      clear_pulses();
      drive(1, 1, 8'h72, 8'h69);
      drain();
      expect_pulse("after_sat", 0, 8'h8c, 8'd1, 1'b0);

      // reset mid-frame
      clear_pulses();
      for (int i = 0; i < 4; i++) drive(1, 0, 8'($urandom), 8'($urandom));
      do_reset(2);
      drive(1, 1, 8'h01, 8'h7e);
      drain();
      expect_pulse("post_reset", 0, 8'h7e, 8'd1, 1'b0);
      check("post_reset_pulses", pulse_q.size(), 1);

      // random frames with bubbles and random last-without-valid noise
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(1, 12);
         for (int t = 0; t < len; t++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            drive(1, t == len - 1, 8'($urandom), 8'($urandom));
         end
         if (f == 20) begin
            for (int i = 0; i < 3; i++) drive(1, 0, 8'($urandom), 8'($urandom));
            idle($urandom_range(0, 12));
            do_reset($urandom_range(1, 3));
         end
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
